mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
Memory-stage access controller. It is the producer side of the MEM/WB pipeline interface.
- Issues data-memory read/write requests to a stallable, multi-cycle data memory (cache) for the instruction held in EX/MEM.
- Freezes the front of the pipeline while an access is outstanding.
- Presents readFromMem and a valid qualifier to the MEM/WB register, so a bubble is written back during stalls.

Parameters:
TIMEOUT, 64, max cycles in BUSY before the sticky error flag sets (legal range 2..255)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
memRead  in  1  EX/MEM instruction loads
memWrite  in  1  EX/MEM instruction stores
HALT  in  1  EX/MEM instruction is HALT; no memory request is issued for it
aluResult  in  16  effective address
writeData  in  16  store data
mem_Stall  in  1  memory cannot accept a new request this cycle
mem_Done  in  1  access completes this cycle; mem_DataOut valid for reads
mem_DataOut  in  16  memory read data
mem_Rd  out  1  read request strobe
mem_Wr  out  1  write request strobe
mem_Addr  out  16  request address (= aluResult)
mem_DataIn  out  16  request write data (= writeData)
readFromMem  out  16  load data to MEM/WB
mwb_valid  out  1  MEM/WB captures the real instruction; 0 = bubble (gate regWrite/HALT)
stall_XM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
err  out  1  sticky: timeout, or memRead&memWrite both high
stall_cnt  out  CNT_W  saturating count of cycles with stall_XM=1

Behaviour:
- States: IDLE, BUSY. State, timeout counter, err and stall_cnt are registered. All other outputs are combinational from the state and inputs.
- req = (memRead | memWrite) & ~HALT.
- memRead & memWrite both high: treated as a write; err sets next cycle.
- IDLE, req=0:
  - no strobes; stall_XM=0; mwb_valid=1; readFromMem=0.
- IDLE, req=1, mem_Stall=1:
  - no strobe; stall_XM=1; mwb_valid=0; stay IDLE and retry next cycle.
- IDLE, req=1, mem_Stall=0:
  - assert mem_Rd or mem_Wr for this cycle only.
  - If mem_Done is also high (hit): stall_XM=0, mwb_valid=1, readFromMem=mem_DataOut when a read (else 0); stay IDLE. Zero added latency.
  - Otherwise: stall_XM=1, mwb_valid=0; go to BUSY; clear the timeout counter.
- BUSY:
  - strobes low; mem_Addr and mem_DataIn keep following EX/MEM, which is frozen.
  - mem_Done=0: stall_XM=1, mwb_valid=0; timeout counter increments.
  - Timeout counter reaches TIMEOUT: err sets. Stay in BUSY; there is no forced exit.
  - mem_Done=1: stall_XM=0, mwb_valid=1, readFromMem=mem_DataOut when the access is a read; go to IDLE.
- Latency:
  - Hit: 1 cycle in MEM.
  - Miss: N+1 cycles, where N = number of BUSY cycles before mem_Done.
  - Loaded data reaches MEM/WB on the mem_Done edge.
- mem_Done while IDLE with no request issued: ignored.
- stall_cnt: +1 on every cycle with stall_XM=1; saturates at all-ones with no wrap.
- rst:
  - state=IDLE; err=0; stall_cnt=0; timeout counter=0.
  - Outputs return to their IDLE/req=0 values the cycle after rst. While rst is high they already follow the IDLE equations.
  - Reset during BUSY abandons the outstanding access; the memory is reset by the same rst.
- HALT: never issues a request. It passes through with mwb_valid=1 and no stall.

Decomposition:
- Shared package/include: state encodings IDLE=1'b0, BUSY=1'b1; a 16-bit word-width constant.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear). Used for both stall_cnt and the timeout counter.
- State flop built from the existing register_1b primitive with en=1.

Test Plan:
1. Load hit: memRead=1, aluResult=16'h0040, mem_Stall=0, mem_Done=1 with mem_DataOut=16'hBEEF in the same cycle -> mem_Rd=1 for 1 cycle; stall_XM=0; mwb_valid=1; readFromMem=16'hBEEF; stall_cnt stays 0.
2. Load miss: mem_Done arrives 3 cycles after the request -> stall_XM=1 for 3 cycles; mwb_valid=0 for those 3 cycles; readFromMem=16'h1234 on the Done cycle; stall_cnt=3.
3. Store under mem_Stall: memWrite=1, mem_Stall=1 for 2 cycles, then 0 with immediate mem_Done -> no mem_Wr for 2 cycles; a single mem_Wr pulse on cycle 3; stall_XM=1 for 2 cycles.
4. Timeout: TIMEOUT=4, miss with no mem_Done -> err=1 after 4 BUSY cycles; stays in BUSY; err stays 1 after a later mem_Done until rst.
5. Reset in BUSY: assert rst mid-miss -> next cycle state=IDLE, stall_XM=0, stall_cnt=0, err=0; a late mem_Done is ignored.
6. HALT with memRead=1, and memRead&memWrite both high -> HALT: no strobe, mwb_valid=1. Both high: mem_Wr pulse only, err=1 next cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
// The state encoding is fixed so the single-bit state flop maps directly onto it.
package mem_stage_ctrl_pkg;
  localparam int WORD_W = 16;
  localparam int TO_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bundles the EX/MEM inputs, data-memory handshake and MEM/WB outputs of the controller.
// The master modport is the controller's view; slave is the pipeline and memory side.
interface mem_stage_ctrl_if
  import mem_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic              memRead;
  logic              memWrite;
  logic              HALT;
  logic [WORD_W-1:0] aluResult;
  logic [WORD_W-1:0] writeData;
  logic              mem_Stall;
  logic              mem_Done;
  logic [WORD_W-1:0] mem_DataOut;
  logic              mem_Rd;
  logic              mem_Wr;
  logic [WORD_W-1:0] mem_Addr;
  logic [WORD_W-1:0] mem_DataIn;
  logic [WORD_W-1:0] readFromMem;
  logic              mwb_valid;
  logic              stall_XM;
  logic              err;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  memRead, memWrite, HALT, aluResult, writeData,
    input  mem_Stall, mem_Done, mem_DataOut,
    output mem_Rd, mem_Wr, mem_Addr, mem_DataIn,
    output readFromMem, mwb_valid, stall_XM, err, stall_cnt
  );

  modport slave (
    output memRead, memWrite, HALT, aluResult, writeData,
    output mem_Stall, mem_Done, mem_DataOut,
    input  mem_Rd, mem_Wr, mem_Addr, mem_DataIn,
    input  readFromMem, mwb_valid, stall_XM, err, stall_cnt
  );
endinterface

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                 q <= '0;
    else if (en && q != '1)  q <= q + 1'b1;
  end
endmodule

// File: rtl/register_1b.sv
// Single-bit register with synchronous active-high reset and load enable.
module register_1b (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= 1'b0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one-cycle read/write strobes to a stallable data memory,
// freezes the front of the pipeline while an access is outstanding, and bubbles MEM/WB.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_stage_ctrl_if.master   bus
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic              state_bit;
  logic              state_next;
  state_t            eff_state;
  logic              req;
  logic              is_read;
  logic              stall;
  logic              to_clr;
  logic              to_inc;
  logic [TO_W-1:0]   to_cnt;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              err_reg;
  logic [WORD_W-1:0] rfm;

  assign req     = (bus.memRead | bus.memWrite) & ~bus.HALT;
  // Both strobes high is resolved as a store.
  assign is_read = bus.memRead & ~bus.memWrite;

  register_1b u_state (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (state_next),
    .q   (state_bit)
  );

  always_comb begin
    // While rst is held the outputs already behave as in IDLE.
    eff_state  = rst ? IDLE : state_t'(state_bit);
    state_next = eff_state;
    bus.mem_Rd = 1'b0;
    bus.mem_Wr = 1'b0;
    stall      = 1'b0;
    rfm        = '0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    case (eff_state)
      IDLE: begin
        if (req) begin
          if (bus.mem_Stall) begin
            stall = 1'b1;
          end else begin
            bus.mem_Rd = is_read;
            bus.mem_Wr = bus.memWrite;
            if (bus.mem_Done) begin
              rfm = is_read ? bus.mem_DataOut : '0;
            end else begin
              stall      = 1'b1;
              state_next = BUSY;
              to_clr     = 1'b1;
            end
          end
        end
      end
      BUSY: begin
        if (bus.mem_Done) begin
          rfm        = is_read ? bus.mem_DataOut : '0;
          state_next = IDLE;
        end else begin
          stall  = 1'b1;
          to_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  sat_counter #(.W(TO_W)) u_timeout (
    .clk (clk),
    .clr (rst | to_clr),
    .en  (to_inc),
    .q   (to_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (stall),
    .q   (stall_cnt_q)
  );

  // Timeout flags on the edge where the BUSY counter reaches TIMEOUT; no forced exit.
  always_ff @(posedge clk) begin
    if (rst)
      err_reg <= 1'b0;
    else if ((bus.memRead & bus.memWrite) | (to_inc & (to_cnt >= TO_LAST)))
      err_reg <= 1'b1;
  end

  assign bus.mem_Addr    = bus.aluResult;
  assign bus.mem_DataIn  = bus.writeData;
  assign bus.readFromMem = rfm;
  assign bus.stall_XM    = stall;
  assign bus.mwb_valid   = ~stall;
  assign bus.err         = err_reg;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule
